// File: rtl/juego_pkg.sv
// Shared types and constants for the board-processing stages (compaction, merge, movement).
package juego_pkg;

  localparam int N          = 4;
  localparam int VICTORIA   = 2048;
  localparam int TILE_W_DEF = 12;

  typedef logic [TILE_W_DEF-1:0] ficha_t;
  typedef ficha_t [N-1:0]        fila_t;
  typedef fila_t  [N-1:0]        tablero_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILA = 2'd2,
    DONE = 2'd3
  } estado_t;

endpackage

// File: rtl/fusion_fila.sv
// Combinational merge-right of one row, followed by right re-compaction.
module fusion_fila
  import juego_pkg::*;
#(
  parameter int TILE_W = 12
) (
  input  logic [N-1:0][TILE_W-1:0] fila_in,
  output logic [N-1:0][TILE_W-1:0] fila_out,
  output logic [TILE_W:0]          puntos_fila,
  output logic                     fusion,
  output logic                     gano_fila
);

  logic [N-1:0][TILE_W-1:0] tmp;
  logic                     salta;
  logic [1:0]               pos;

  // Scan from column 3 down; a merged pair consumes both cells, so the next
  // column is skipped to keep each tile in at most one merge. 2048 never merges.
  always_comb begin
    tmp         = fila_in;
    puntos_fila = '0;
    fusion      = 1'b0;
    gano_fila   = 1'b0;
    salta       = 1'b0;
    for (int i = N - 1; i >= 1; i--) begin
      if (salta) begin
        salta = 1'b0;
      end else if ((fila_in[i] != '0) && (fila_in[i] == fila_in[i-1]) &&
                   (fila_in[i] != TILE_W'(VICTORIA))) begin
        tmp[i]      = fila_in[i] << 1;
        tmp[i-1]    = '0;
        puntos_fila = puntos_fila + (TILE_W+1)'(tmp[i]);
        fusion      = 1'b1;
        if (tmp[i] == TILE_W'(VICTORIA)) gano_fila = 1'b1;
        salta       = 1'b1;
      end
    end
  end

  always_comb begin
    fila_out = '0;
    pos      = 2'd3;
    for (int i = N - 1; i >= 0; i--) begin
      if (tmp[i] != '0) begin
        fila_out[pos] = tmp[i];
        pos           = pos - 2'd1;
      end
    end
  end

endmodule

// File: rtl/combinar_derecha.sv
// Right-merge pass over a 4x4 board: captures the board, merges one row per
// cycle through a shared fusion_fila, and publishes the result on DONE.
module combinar_derecha
  import juego_pkg::*;
#(
  parameter int TILE_W  = 12,
  parameter int SCORE_W = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [N-1:0][N-1:0][TILE_W-1:0] matriz_in,
  output logic [N-1:0][N-1:0][TILE_W-1:0] matriz,
  output logic                            busy,
  output logic                            done,
  output logic [SCORE_W-1:0]              puntos,
  output logic                            cambio,
  output logic                            gano,
  output estado_t                         estado
);

  // Handshake: start is a level sampled only in IDLE; busy covers LOAD..DONE;
  // done is a single-cycle pulse and results stay stable until the next LOAD.

  localparam int SUM_W = ((SCORE_W > TILE_W + 1) ? SCORE_W : TILE_W + 1) + 1;

  estado_t                         est, est_sig;
  logic [1:0]                      fila_cnt;
  logic [N-1:0][N-1:0][TILE_W-1:0] tablero, tablero_fin;
  logic [N-1:0][TILE_W-1:0]        fila_sel, fila_res;
  logic [TILE_W:0]                 pts_fila;
  logic                            fus_fila, gano_fila;
  logic [SUM_W-1:0]                suma;
  logic [SCORE_W-1:0]              puntos_sig;

  assign fila_sel = tablero[fila_cnt];

  fusion_fila #(.TILE_W(TILE_W)) u_fusion (
    .fila_in    (fila_sel),
    .fila_out   (fila_res),
    .puntos_fila(pts_fila),
    .fusion     (fus_fila),
    .gano_fila  (gano_fila)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) est <= IDLE;
    else        est <= est_sig;
  end

  always_comb begin
    est_sig = est;
    case (est)
      IDLE:    if (start) est_sig = LOAD;
      LOAD:    est_sig = FILA;
      FILA:    if (fila_cnt == 2'd3) est_sig = DONE;
      DONE:    est_sig = IDLE;
      default: est_sig = IDLE;
    endcase
  end

  // Score accumulates with saturation at the all-ones value.
  always_comb begin
    suma       = SUM_W'(puntos) + SUM_W'(pts_fila);
    puntos_sig = (suma > SUM_W'({SCORE_W{1'b1}})) ? '1 : suma[SCORE_W-1:0];
  end

  // Final board including the row being merged this cycle, so matriz can be
  // loaded in one shot on the transition into DONE.
  always_comb begin
    tablero_fin           = tablero;
    tablero_fin[fila_cnt] = fila_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tablero  <= '0;
      matriz   <= '0;
      fila_cnt <= 2'd0;
      puntos   <= '0;
      cambio   <= 1'b0;
      gano     <= 1'b0;
    end else begin
      case (est)
        LOAD: begin
          tablero  <= matriz_in;
          fila_cnt <= 2'd0;
          puntos   <= '0;
          cambio   <= 1'b0;
          gano     <= 1'b0;
        end
        FILA: begin
          tablero[fila_cnt] <= fila_res;
          fila_cnt          <= fila_cnt + 2'd1;
          puntos            <= puntos_sig;
          cambio            <= cambio | fus_fila;
          gano              <= gano | gano_fila;
          if (fila_cnt == 2'd3) matriz <= tablero_fin;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (est != IDLE);
  assign done   = (est == DONE);
  assign estado = est;

endmodule

// File: tb/tb_combinar_derecha.sv
// Directed bench for combinar_derecha: hand-computed boards, latency, busy/done
// behaviour, mid-pass reset and score saturation on a narrow-score instance.
module tb_combinar_derecha;
  import juego_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     start = 1'b0;
  tablero_t matriz_in = '0;
  tablero_t matriz, matriz_s, exp_m, mixto;
  logic     busy, done, cambio, gano;
  logic     busy_s, done_s, cambio_s, gano_s;
  logic [15:0] puntos;
  logic [7:0]  puntos_s;
  estado_t  estado, estado_s;

  int errors = 0;
  int checks = 0;
  int lat, nd;

  always #5 clk = ~clk;

  combinar_derecha #(.TILE_W(12), .SCORE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matriz_in(matriz_in),
    .matriz(matriz), .busy(busy), .done(done), .puntos(puntos),
    .cambio(cambio), .gano(gano), .estado(estado)
  );

  combinar_derecha #(.TILE_W(12), .SCORE_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .matriz_in(matriz_in),
    .matriz(matriz_s), .busy(busy_s), .done(done_s), .puntos(puntos_s),
    .cambio(cambio_s), .gano(gano_s), .estado(estado_s)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Rows are written as [c0, c1, c2, c3]; column 3 is the right edge.
  task automatic set_in(input int f, input int c0, input int c1, input int c2, input int c3);
    matriz_in[f][0] = 12'(c0);
    matriz_in[f][1] = 12'(c1);
    matriz_in[f][2] = 12'(c2);
    matriz_in[f][3] = 12'(c3);
  endtask

  task automatic set_exp(input int f, input int c0, input int c1, input int c2, input int c3);
    exp_m[f][0] = 12'(c0);
    exp_m[f][1] = 12'(c1);
    exp_m[f][2] = 12'(c2);
    exp_m[f][3] = 12'(c3);
  endtask

  // Start is raised just before a rising edge; lat counts falling edges until done.
  task automatic run_pass(input bit interf, output int lat_o, output int nd_o);
    lat_o = -1;
    nd_o  = 0;
    start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk("busy_load", busy, 1'b1);
      end
      if (interf) begin
        if (k >= 2 && k <= 4) begin
          start     = 1'b1;
          matriz_in = ~matriz_in;
        end else begin
          start = 1'b0;
        end
      end
      if (done) begin
        nd_o++;
        if (lat_o < 0) lat_o = k;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string p, input int pts, input bit cam, input bit gan);
    chk({p, "_latency"}, lat, 6);
    chk({p, "_done_count"}, nd, 1);
    chk({p, "_matriz"}, matriz, exp_m);
    chk({p, "_puntos"}, puntos, 16'(pts));
    chk({p, "_cambio"}, cambio, cam);
    chk({p, "_gano"}, gano, gan);
    chk({p, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    int found, t1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_matriz", matriz, '0);
    chk("rst_puntos", puntos, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_estado", estado, IDLE);
    chk("rst_cambio", cambio, 1'b0);
    chk("rst_gano", gano, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // [2,2,2,2] -> [0,0,4,4]
    matriz_in = '0; exp_m = '0;
    set_in(0, 2, 2, 2, 2); set_exp(0, 0, 0, 4, 4);
    run_pass(1'b0, lat, nd);
    check_result("p1", 8, 1'b1, 1'b0);
    chk("p1_puntos_narrow", puntos_s, 8'd8);

    // [0,4,4,8] -> [0,0,8,8], no cascade
    matriz_in = '0; exp_m = '0;
    set_in(1, 0, 4, 4, 8); set_exp(1, 0, 0, 8, 8);
    run_pass(1'b0, lat, nd);
    check_result("p2", 8, 1'b1, 1'b0);

    // 1024 pair makes 2048; 2048 pairs never merge; narrow score saturates
    matriz_in = '0; exp_m = '0;
    set_in(2, 1024, 1024, 2048, 2048); set_exp(2, 0, 2048, 2048, 2048);
    set_in(3, 0, 0, 2048, 2048);       set_exp(3, 0, 0, 2048, 2048);
    run_pass(1'b0, lat, nd);
    check_result("p3", 2048, 1'b1, 1'b1);
    chk("p3_puntos_sat", puntos_s, 8'd255);

    // Nothing merges
    for (int f = 0; f < 4; f++) begin
      set_in(f, 2, 4, 8, 16);
      set_exp(f, 2, 4, 8, 16);
    end
    run_pass(1'b0, lat, nd);
    check_result("p4", 0, 1'b0, 1'b0);

    // All zero
    matriz_in = '0; exp_m = '0;
    run_pass(1'b0, lat, nd);
    check_result("p5", 0, 1'b0, 1'b0);

    // Mixed board: double merge, odd triple, single tile, triple of 8
    matriz_in = '0; exp_m = '0;
    set_in(0, 2, 2, 4, 4); set_exp(0, 0, 0, 4, 8);
    set_in(1, 0, 2, 2, 2); set_exp(1, 0, 0, 2, 4);
    set_in(2, 0, 0, 0, 2); set_exp(2, 0, 0, 0, 2);
    set_in(3, 0, 8, 8, 8); set_exp(3, 0, 0, 8, 16);
    mixto = matriz_in;
    run_pass(1'b0, lat, nd);
    check_result("p6", 32, 1'b1, 1'b0);

    // Start pulses while busy and input changes after LOAD are ignored
    matriz_in = mixto;
    run_pass(1'b1, lat, nd);
    check_result("p7", 32, 1'b1, 1'b0);

    // Mid-pass reset: outputs clear without a clock edge, no done pulse
    matriz_in = mixto;
    nd = 0;
    start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) nd++;
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_matriz", matriz, '0);
    chk("mrst_puntos", puntos, '0);
    chk("mrst_cambio", cambio, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_estado", estado, IDLE);
    repeat (2) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mrst_no_done", nd, 0);
    rst_n = 1'b1;
    run_pass(1'b0, lat, nd);
    check_result("p8", 32, 1'b1, 1'b0);

    // Start held high: one pass every 7 cycles
    start = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    chk("cont_first_done", found, 1);
    found = 0;
    t1 = 0;
    for (int i = 1; i <= 30 && found == 0; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        t1 = i;
      end
    end
    start = 1'b0;
    chk("cont_second_done", found, 1);
    chk("cont_period", t1, 7);
    repeat (10) @(negedge clk);
    chk("cont_matriz", matriz, exp_m);
    chk("cont_idle", estado, IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/combinar_derecha.md
COMBINAR_DERECHA -- requirements
Module: combinar_derecha

Interface
REQ-001 The block SHALL have parameter TILE_W, default 12, tile width in bits.
REQ-002 The block SHALL have parameter SCORE_W, default 16, score accumulator width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 Port start  input  1  request a merge pass; sampled only in IDLE.
REQ-006 Port matriz_in  input  4x4xTILE_W  board already right-compacted, indexed [fila][columna]; 0 means empty.
REQ-007 Port matriz  output  4x4xTILE_W  merged and re-compacted board.
REQ-008 Port busy  output  1  high while a pass is in progress (LOAD through DONE).
REQ-009 Port done  output  1  one-cycle pulse; matriz, puntos, cambio and gano are valid from this cycle on.
REQ-010 Port puntos  output  SCORE_W  sum of all merged tile values produced in the last pass.
REQ-011 Port cambio  output  1  at least one merge occurred in the last pass.
REQ-012 Port gano  output  1  some merge in the last pass produced the value 2048.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, FILA, DONE.
- IDLE->LOAD on start=1.
- LOAD->FILA after 1 cycle.
- FILA->DONE after row 3.
- DONE->IDLE after 1 cycle.
REQ-014 LOAD SHALL capture matriz_in into an internal register, clear the accumulators, and set the row counter to 0.
- Later changes to matriz_in SHALL not affect the pass.
REQ-015 FILA SHALL process one row per cycle in order 0,1,2,3 using a 2-bit row counter.
- FILA lasts exactly 4 cycles.
REQ-016 The row merge SHALL scan right to left. With cells c3..c0:
- If c3==c2!=0: out3=2*c3; then compare c1 with c0.
- Otherwise compare c2 with c1, then c1 with c0, using the same rule.
- A tile SHALL take part in at most one merge per pass.
REQ-017 After merging, the row SHALL be re-compacted right: non-zero values keep their order and fill from column 3 downward; freed cells become 0.
REQ-018 Tiles with value 2048 SHALL NOT merge with each other, so 4096 is never produced and TILE_W never overflows.
REQ-019 For every merge, the merged value SHALL be added to puntos, saturating at 2^SCORE_W-1.
- Each merge SHALL also set cambio.
- A result of 2048 SHALL also set gano.
REQ-020 done SHALL be high exactly in DONE.
- Latency from the cycle start is sampled to done is 6 cycles.
REQ-021 busy SHALL be high in LOAD, FILA and DONE, and low in IDLE.
REQ-022 start asserted while busy=1 SHALL be ignored, and SHALL NOT be queued.
REQ-023 matriz, puntos, cambio and gano SHALL hold their values from DONE until the next LOAD.
- matriz SHALL update only at DONE entry, so partially processed rows are never visible.
REQ-024 start held high continuously SHALL start a new pass on each return to IDLE, giving one pass per 7 cycles.
REQ-025 An all-zero input SHALL produce an all-zero output with puntos=0, cambio=0 and gano=0.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, without waiting for a clock edge:
- force state IDLE;
- clear matriz, internal board, row counter, puntos, cambio, gano, done and busy to 0.
REQ-027 Reset asserted mid-pass SHALL abandon the pass without a done pulse.
- The first start after rst_n deasserts SHALL be honoured on the next rising edge.

Structure
REQ-028 The following SHALL live in shared package juego_pkg and be reused by the compaction and movement stages:
- typedef fila_t = 4xTILE_W;
- typedef tablero_t = 4x4xTILE_W;
- constants VICTORIA=2048 and N=4;
- the FSM state enum.
REQ-029 The per-row merge-and-recompact logic SHALL be the combinational sub-module fusion_fila.
- Inputs: one fila_t.
- Outputs: merged fila_t, row points, merged flag, 2048 flag.
- combinar_derecha SHALL instantiate it once and time-multiplex it across the rows.

Verification
REQ-030 Row 0 = [2,2,2,2], other rows 0, start pulse -> done 6 cycles later; row 0=[0,0,4,4]; puntos=8; cambio=1; gano=0.
REQ-031 Row 1 = [0,4,4,8] -> row 1=[0,0,8,8]; puntos=8; no cascade to 16.
REQ-032 Row 2 = [1024,1024,2048,2048] -> row 2=[0,2048,2048,2048]; puntos=2048; gano=1.
REQ-033 All rows [2,4,8,16] -> output equals input; puntos=0; cambio=0; done still pulses after 6 cycles.
REQ-034 Drop rst_n low 3 cycles after start -> outputs 0 immediately, no done pulse; new start after release -> normal result.
REQ-035 start pulses during busy plus matriz_in changes after LOAD -> exactly one done per accepted start; result reflects the board captured at LOAD.
